// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment glyphs and scan FSM state encoding
package seg_pkg;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_ON   = 2'd1,
      ST_DEAD = 2'd2
   } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit value plus blank/dp flags to an active-low {dp,g..a} code
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] val,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] seg_n
);

   logic [6:0] glyph;

   // glyph lookup; non-decimal values render as a dash
   always_comb begin
      case (val)
         4'd0:    glyph = SEG_0;
         4'd1:    glyph = SEG_1;
         4'd2:    glyph = SEG_2;
         4'd3:    glyph = SEG_3;
         4'd4:    glyph = SEG_4;
         4'd5:    glyph = SEG_5;
         4'd6:    glyph = SEG_6;
         4'd7:    glyph = SEG_7;
         4'd8:    glyph = SEG_8;
         4'd9:    glyph = SEG_9;
         default: glyph = SEG_DASH;
      endcase
   end

   // a blanked digit keeps its decimal point
   assign seg_n = {~dp, blank ? SEG_BLANK : glyph};

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed seven-segment scanner with frame-coherent capture
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 10,
   parameter int DEAD_CYC = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] dig0,
   input  logic [3:0] dig1,
   input  logic [3:0] dig2,
   input  logic [3:0] dig3,
   input  logic [3:0] dp_en,
   input  logic       lz_en,
   input  logic       disp_en,
   output logic [7:0] seg_n,
   output logic [3:0] sel_n,
   output logic       frame_tick
);

   localparam int MAXC = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] ON_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

   scan_state_t     state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0][3:0] sh_dig_q, sh_dig_d;
   logic [3:0]      sh_dp_q, sh_dp_d;
   logic            sh_lz_q, sh_lz_d;
   logic [7:0]      seg_n_q, seg_n_d;
   logic [3:0]      sel_n_q, sel_n_d;
   logic            ft_q, ft_d;
   logic [3:0]      blank_v;
   logic [7:0]      dec_seg_n;
   logic            lit;

   // leading-zero blanking ripples down from the most significant digit
   assign blank_v[3] = sh_lz_q && (sh_dig_q[3] == 4'd0);
   assign blank_v[2] = blank_v[3] && (sh_dig_q[2] == 4'd0);
   assign blank_v[1] = blank_v[2] && (sh_dig_q[1] == 4'd0);
   assign blank_v[0] = 1'b0;

   seg7_decode u_dec (
      .val   (sh_dig_q[idx_q]),
      .blank (blank_v[idx_q]),
      .dp    (sh_dp_q[idx_q]),
      .seg_n (dec_seg_n)
   );

   // scan schedule: LOAD once per frame, then ON/DEAD for each digit
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      sh_dig_d = sh_dig_q;
      sh_dp_d  = sh_dp_q;
      sh_lz_d  = sh_lz_q;
      case (state_q)
         ST_LOAD: begin
            sh_dig_d = {dig3, dig2, dig1, dig0};
            sh_dp_d  = dp_en;
            sh_lz_d  = lz_en;
            idx_d    = 2'd0;
            cnt_d    = '0;
            state_d  = ST_ON;
         end
         ST_ON: begin
            cnt_d   = (cnt_q == ON_LAST) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == ON_LAST) ? ST_DEAD : ST_ON;
         end
         ST_DEAD: begin
            cnt_d = (cnt_q == DEAD_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == DEAD_LAST) begin
               state_d = (idx_q == 2'd3) ? ST_LOAD : ST_ON;
               idx_d   = (idx_q == 2'd3) ? idx_q : idx_q + 2'd1;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // outputs trail the state by one register stage; disp_en gates them live
   always_comb begin
      lit     = disp_en && (state_q == ST_ON);
      sel_n_d = lit ? ~(4'b0001 << idx_q) : 4'hF;
      seg_n_d = lit ? dec_seg_n : 8'hFF;
      ft_d    = (state_q == ST_LOAD);
   end

   // state, shadow and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_LOAD;
         idx_q    <= 2'd0;
         cnt_q    <= '0;
         sh_dig_q <= '0;
         sh_dp_q  <= '0;
         sh_lz_q  <= 1'b0;
         seg_n_q  <= 8'hFF;
         sel_n_q  <= 4'hF;
         ft_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         sh_dig_q <= sh_dig_d;
         sh_dp_q  <= sh_dp_d;
         sh_lz_q  <= sh_lz_d;
         seg_n_q  <= seg_n_d;
         sel_n_q  <= sel_n_d;
         ft_q     <= ft_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign sel_n      = sel_n_q;
   assign frame_tick = ft_q;

endmodule
